// File: rtl/keypad_input_reader.sv
// Keypad scanner: reads a 74HC165-style PISO chain, debounces whole-keypad
// snapshots and hands single-key press events to the core over valid/ready.
module keypad_input_reader #(
  parameter  int unsigned NUM_KEYS       = 16,
  parameter  int unsigned DEBOUNCE_SCANS = 4,
  localparam int unsigned KEY_WIDTH      = $clog2(NUM_KEYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sr_data,
  output logic                 o_sr_clk,
  output logic                 o_sr_load_n,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overflow
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [1:0] ST_LOAD     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_EVAL     = 2'd3;

  localparam logic [KEY_WIDTH-1:0] LAST_BIT = KEY_WIDTH'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [NUM_KEYS-1:0]  ONE      = NUM_KEYS'(1);

  logic [1:0]           state,  state_nx;
  logic [KEY_WIDTH-1:0] bitcnt, bitcnt_nx;
  logic [NUM_KEYS-1:0]  raw,    raw_nx;
  logic [NUM_KEYS-1:0]  prev,   prev_nx;
  logic [NUM_KEYS-1:0]  stable, stable_nx;
  logic [CNT_W-1:0]     cnt,    cnt_nx;
  logic                 sr_clk_nx, sr_load_n_nx;
  logic                 valid_nx, overflow_nx;
  logic [KEY_WIDTH-1:0] key_nx;

  // Scratch values used only inside the combinational block
  logic [CNT_W-1:0]     cnt_upd;
  logic                 fire;
  logic [KEY_WIDTH-1:0] fire_idx;
  logic [KEY_WIDTH-1:0] sample_idx;

  // State and output registers; pins are decoded from the current state and
  // therefore show each state's levels one cycle later, which puts the load
  // pulse ahead of the first sample and every shift edge ahead of its sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      bitcnt      <= '0;
      raw         <= '0;
      prev        <= '0;
      stable      <= '0;
      cnt         <= '0;
      o_sr_clk    <= 1'b0;
      o_sr_load_n <= 1'b1;
      o_valid     <= 1'b0;
      o_key       <= '0;
      o_overflow  <= 1'b0;
    end else begin
      state       <= state_nx;
      bitcnt      <= bitcnt_nx;
      raw         <= raw_nx;
      prev        <= prev_nx;
      stable      <= stable_nx;
      cnt         <= cnt_nx;
      o_sr_clk    <= sr_clk_nx;
      o_sr_load_n <= sr_load_n_nx;
      o_valid     <= valid_nx;
      o_key       <= key_nx;
      o_overflow  <= overflow_nx;
    end
  end

  // Scan sequencing, debounce, event detection and the single-entry output slot
  always_comb begin
    state_nx     = state;
    bitcnt_nx    = bitcnt;
    raw_nx       = raw;
    prev_nx      = prev;
    stable_nx    = stable;
    cnt_nx       = cnt;
    sr_clk_nx    = 1'b0;
    sr_load_n_nx = 1'b1;
    valid_nx     = o_valid;
    key_nx       = o_key;
    overflow_nx  = 1'b0;
    cnt_upd      = cnt;
    fire         = 1'b0;
    fire_idx     = '0;
    sample_idx   = LAST_BIT - bitcnt;

    case (state)
      ST_LOAD: begin
        sr_load_n_nx = 1'b0;
        bitcnt_nx    = '0;
        state_nx     = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        raw_nx[sample_idx] = i_sr_data;
        state_nx           = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        sr_clk_nx = 1'b1;
        if (bitcnt == LAST_BIT) begin
          state_nx = ST_EVAL;
        end else begin
          bitcnt_nx = bitcnt + KEY_WIDTH'(1);
          state_nx  = ST_SHIFT_LO;
        end
      end
      default: begin
        // A snapshot is accepted once it has repeated for DEBOUNCE_SCANS scans
        if (raw == prev) begin
          cnt_upd = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else begin
          cnt_upd = CNT_W'(1);
        end
        cnt_nx  = cnt_upd;
        prev_nx = raw;
        if ((cnt_upd == CNT_MAX) && (raw != stable)) begin
          stable_nx = raw;
          // Only a lone key that was not already down counts as a new press
          if ((raw != '0) && ((raw & (raw - ONE)) == '0) && ((raw & stable) == '0)) begin
            fire = 1'b1;
          end
        end
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
          if (raw[i]) begin
            fire_idx = KEY_WIDTH'(i);
          end
        end
        state_nx = ST_LOAD;
      end
    endcase

    // A handshake in the same cycle frees the slot for the incoming event
    if (fire) begin
      if (!o_valid || i_ready) begin
        valid_nx = 1'b1;
        key_nx   = fire_idx;
      end else begin
        overflow_nx = 1'b1;
      end
    end else if (o_valid && i_ready) begin
      valid_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_input_reader.sv
// Randomised and directed bench for keypad_input_reader with a keypad/chain
// model, a scan-level reference model and a scoreboard on the output slot.
module tb_keypad_input_reader;

  localparam int unsigned NK   = 16;
  localparam int unsigned DS   = 4;
  localparam int unsigned KW   = 4;
  localparam int unsigned SCAN = 2 * NK + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_sr_data;
  logic          o_sr_clk;
  logic          o_sr_load_n;
  logic [KW-1:0] o_key;
  logic          o_valid;
  logic          i_ready;
  logic          o_overflow;

  logic [NK-1:0] keys;
  logic [NK-1:0] chain;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int ovf_cnt  = 0;

  logic [KW-1:0] q[$];
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_stable = '0;
  logic          ovf_pend = 1'b0;

  always #5 clk = ~clk;

  keypad_input_reader #(.NUM_KEYS(NK), .DEBOUNCE_SCANS(DS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sr_data  (i_sr_data),
    .o_sr_clk   (o_sr_clk),
    .o_sr_load_n(o_sr_load_n),
    .o_key      (o_key),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
  );

  // 74HC165-style chain: load while PL is low, shift toward the output on a rising clock
  assign i_sr_data = chain[NK-1];
  initial forever begin
    @(negedge o_sr_load_n or posedge o_sr_clk);
    if (!o_sr_load_n) chain = keys;
    else              chain = {chain[NK-2:0], 1'b0};
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NK-1:0] onehot(input int i);
    return NK'(1) << i;
  endfunction

  // Clock edges since reset release; scan k's EVAL edge is edge k*SCAN
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) cyc = 0;
    else        cyc++;
  end

  // Monitor, scoreboard and reference model, all evaluated mid-cycle
  initial begin : monitor
    int       last_load;
    bit       have_load;
    int       rises;
    logic     clk_prev;
    logic [NK-1:0] snap, old;
    bit       all_eq;
    int       idx;
    have_load = 0; last_load = 0; rises = 0; clk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        q.delete(); hist.delete(); m_stable = '0; ovf_pend = 1'b0;
        have_load = 0; rises = 0; clk_prev = 1'b0;
      end else begin
        // Chain pin waveform: one load per scan period, NK shift edges between loads
        if (o_sr_clk && !clk_prev) rises++;
        clk_prev = o_sr_clk;
        if (!o_sr_load_n) begin
          if (have_load) begin
            chk("load_period", cyc - last_load, SCAN);
            chk("clk_rises_per_scan", rises, NK);
          end
          have_load = 1; last_load = cyc; rises = 0;
        end
        // Output slot against the scoreboard
        chk("overflow", o_overflow, ovf_pend);
        if (o_overflow) ovf_cnt++;
        ovf_pend = 1'b0;
        chk("valid", o_valid, q.size() != 0);
        if (o_valid && q.size() != 0) chk("key", o_key, q[0]);
        if (o_valid && i_ready && q.size() != 0) begin
          void'(q.pop_front());
          hs_cnt++;
        end
        // Reference model: the next edge ends a scan whose snapshot is `keys`
        if ((cyc + 1) % SCAN == 0) begin
          snap = keys;
          hist.push_back(snap);
          if (hist.size() > DS) void'(hist.pop_front());
          all_eq = (hist.size() == DS);
          foreach (hist[i]) if (hist[i] != snap) all_eq = 0;
          if (all_eq && snap != m_stable) begin
            old = m_stable;
            m_stable = snap;
            if ($countones(snap) == 1 && (snap & old) == '0) begin
              idx = 0;
              for (int i = 0; i < NK; i++) if (snap[i]) idx = i;
              if (q.size() != 0) ovf_pend = 1'b1;
              else               q.push_back(KW'(idx));
            end
          end
        end
      end
    end
  end

  task automatic run_scans(input logic [NK-1:0] pat, input int n, input bit rnd_ready);
    for (int s = 0; s < n; s++) begin
      keys = pat;
      for (int c = 0; c < SCAN; c++) begin
        @(posedge clk); #1;
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_reset(input logic [NK-1:0] pat);
    @(negedge clk); #1;
    rst_n = 1'b0;
    keys  = pat;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_load_n"}, o_sr_load_n, 1);
    chk({nm, "_sr_clk"}, o_sr_clk, 0);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_key"}, o_key, 0);
    chk({nm, "_overflow"}, o_overflow, 0);
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!o_valid && t < 8 * SCAN) begin
      @(negedge clk);
      t++;
    end
    chk(nm, cyc, 4 * SCAN);
  endtask

  task automatic sync_scan();
    do begin
      @(posedge clk); #1;
    end while (cyc % SCAN != 0);
  endtask

  initial begin : stim
    int hs0, ovf0, n;
    logic [NK-1:0] pat;
    rst_n = 1'b1; keys = '0; i_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle scanning: no events
    run_scans('0, 3, 0);

    // Key 5 from the first scan: latency, one handshake, no repeat while held
    do_reset(onehot(5));
    hs0 = hs_cnt;
    wait_valid("key5_latency");
    chk("key5_key", o_key, 5);
    sync_scan();
    run_scans(onehot(5), 20, 0);
    chk("key5_handshakes", hs_cnt - hs0, 1);

    // Bouncing key 9, then hold, release and re-press
    run_scans('0, 5, 0);
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      run_scans(onehot(9), 1, 0);
      run_scans('0, 1, 0);
    end
    chk("bounce_no_event", hs_cnt - hs0, 0);
    run_scans(onehot(9), 5, 0);
    run_scans('0, 5, 0);
    run_scans(onehot(9), 5, 0);
    chk("bounce_two_events", hs_cnt - hs0, 2);

    // Two keys together, then drop one: nothing fires
    run_scans('0, 5, 0);
    hs0 = hs_cnt;
    run_scans(onehot(2) | onehot(3), 10, 0);
    run_scans(onehot(2), 6, 0);
    run_scans('0, 5, 0);
    chk("multikey_no_event", hs_cnt - hs0, 0);

    // Backpressure: key 1 held in the slot, key 7 dropped with an overflow pulse
    i_ready = 1'b0;
    ovf0 = ovf_cnt;
    run_scans(onehot(1), 5, 0);
    run_scans('0, 5, 0);
    run_scans(onehot(7), 5, 0);
    chk("ovf_pulses", ovf_cnt - ovf0, 1);
    chk("ovf_valid_held", o_valid, 1);
    chk("ovf_key_held", o_key, 1);
    i_ready = 1'b1;
    run_scans('0, 1, 0);
    chk("ovf_drained", o_valid, 0);

    // Key 4 pending; i_ready only during key 12's accepting EVAL cycle
    i_ready = 1'b0;
    run_scans(onehot(4), 5, 0);
    run_scans('0, 5, 0);
    run_scans(onehot(12), 3, 0);
    hs0 = hs_cnt;
    keys = onehot(12);
    repeat (SCAN - 1) begin @(posedge clk); #1; end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("simul_valid", o_valid, 1);
    chk("simul_key", o_key, 12);
    chk("simul_no_ovf", o_overflow, 0);
    chk("simul_handshake", hs_cnt - hs0, 1);
    i_ready = 1'b1;
    run_scans(onehot(12), 2, 0);

    // Reset in the middle of shifting restarts the full debounce
    run_scans(onehot(3), 2, 0);
    keys = onehot(3);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midscan_reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_valid("restart_latency");
    chk("restart_key", o_key, 3);
    sync_scan();

    // Random keypad activity with random backpressure
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       pat = '0;
        3:       pat = onehot(int'($urandom_range(0, NK - 1))) | onehot(int'($urandom_range(0, NK - 1)));
        default: pat = onehot(int'($urandom_range(0, NK - 1)));
      endcase
      n = int'($urandom_range(1, 6));
      run_scans(pat, n, 1);
    end
    i_ready = 1'b1;
    run_scans('0, 6, 0);
    chk("final_queue_empty", q.size(), 0);
    chk("final_valid", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
